// File: rtl/ifmap_read_sched.sv
// Ifmap read scheduler: configures the read-address generator once per layer, then
// streams one bank's worth of reads per tile and hands the bank back to the writer.
module ifmap_read_sched #(
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int TILE_WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [9*BANK_ADDR_WIDTH-1:0] cfg_data,
    input  logic [TILE_WIDTH-1:0]        cfg_tiles,
    input  logic                         bank_ready,
    input  logic                         stall,
    output logic                         gen_config_en,
    output logic [9*BANK_ADDR_WIDTH-1:0] gen_config_data,
    output logic                         gen_adr_en,
    output logic                         read_valid,
    output logic                         last_read,
    output logic                         bank_release,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);
    localparam int W  = BANK_ADDR_WIDTH;
    localparam int CW = 9 * W;
    localparam int TW = 6 * W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_WAIT_BANK,
        S_RUN,
        S_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cfg_q, cfg_d;
    logic [TILE_WIDTH-1:0] tiles_q, tiles_d;
    logic [TW-1:0]         total_q, total_d;
    logic [TW-1:0]         read_cnt_q, read_cnt_d;
    logic [TILE_WIDTH-1:0] tile_cnt_q, tile_cnt_d;
    logic                  gen_config_en_q, gen_config_en_d;
    logic                  read_valid_q, read_valid_d;
    logic                  last_read_q, last_read_d;
    logic                  bank_release_q, bank_release_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;

    logic [W-1:0]  ox0, oy0, fx, fy, ic1, oc1;
    logic [TW-1:0] total_calc;
    logic          cfg_zero;
    logic          is_last_read;
    logic          is_last_tile;

    function automatic logic [TW-1:0] ext(input logic [W-1:0] v);
        return {{(TW - W){1'b0}}, v};
    endfunction

    // Field order is {OX0, OY0, FX, FY, STRIDE, IX0, IY0, IC1, OC1}, MSB first.
    assign ox0 = cfg_q[9*W-1 -: W];
    assign oy0 = cfg_q[8*W-1 -: W];
    assign fx  = cfg_q[7*W-1 -: W];
    assign fy  = cfg_q[6*W-1 -: W];
    assign ic1 = cfg_q[2*W-1 -: W];
    assign oc1 = cfg_q[W-1:0];

    // Full-width product: six W-bit factors never overflow 6*W bits.
    assign total_calc = ext(ox0) * ext(oy0) * ext(fx) * ext(fy) * ext(ic1) * ext(oc1);
    assign cfg_zero   = (ox0 == '0) || (oy0 == '0) || (fx == '0) || (fy == '0) ||
                        (ic1 == '0) || (oc1 == '0) || (tiles_q == '0);

    assign gen_adr_en   = (state_q == S_RUN) && !stall;
    assign is_last_read = (read_cnt_q == total_q - TW'(1));
    assign is_last_tile = (tile_cnt_q == tiles_q - TILE_WIDTH'(1));

    always_comb begin
        state_d         = state_q;
        cfg_d           = cfg_q;
        tiles_d         = tiles_q;
        total_d         = total_q;
        read_cnt_d      = read_cnt_q;
        tile_cnt_d      = tile_cnt_q;
        gen_config_en_d = 1'b0;
        bank_release_d  = 1'b0;
        done_d          = 1'b0;
        cfg_err_d       = 1'b0;
        read_valid_d    = gen_adr_en;
        last_read_d     = gen_adr_en && is_last_read;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d           = cfg_data;
                    tiles_d         = cfg_tiles;
                    gen_config_en_d = 1'b1;
                    state_d         = S_CONFIG;
                end
            end
            S_CONFIG: begin
                total_d    = total_calc;
                read_cnt_d = '0;
                tile_cnt_d = '0;
                if (cfg_zero) begin
                    done_d    = 1'b1;
                    cfg_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WAIT_BANK;
                end
            end
            S_WAIT_BANK: begin
                if (bank_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Release/done pulses are registered so they land in the RELEASE cycle.
                if (gen_adr_en) begin
                    if (is_last_read) begin
                        bank_release_d = 1'b1;
                        done_d         = is_last_tile;
                        state_d        = S_RELEASE;
                    end else begin
                        read_cnt_d = read_cnt_q + TW'(1);
                    end
                end
            end
            S_RELEASE: begin
                read_cnt_d = '0;
                tile_cnt_d = tile_cnt_q + TILE_WIDTH'(1);
                state_d    = is_last_tile ? S_IDLE : S_WAIT_BANK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cfg_q           <= '0;
            tiles_q         <= '0;
            total_q         <= '0;
            read_cnt_q      <= '0;
            tile_cnt_q      <= '0;
            gen_config_en_q <= 1'b0;
            read_valid_q    <= 1'b0;
            last_read_q     <= 1'b0;
            bank_release_q  <= 1'b0;
            done_q          <= 1'b0;
            cfg_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cfg_q           <= cfg_d;
            tiles_q         <= tiles_d;
            total_q         <= total_d;
            read_cnt_q      <= read_cnt_d;
            tile_cnt_q      <= tile_cnt_d;
            gen_config_en_q <= gen_config_en_d;
            read_valid_q    <= read_valid_d;
            last_read_q     <= last_read_d;
            bank_release_q  <= bank_release_d;
            done_q          <= done_d;
            cfg_err_q       <= cfg_err_d;
        end
    end

    assign gen_config_en   = gen_config_en_q;
    assign gen_config_data = cfg_q;
    assign read_valid      = read_valid_q;
    assign last_read       = last_read_q;
    assign bank_release    = bank_release_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_ifmap_read_sched.sv
// Directed bench for ifmap_read_sched: a negedge monitor collects event counts and
// cycle stamps, the main sequence compares them with hand-derived values.
module tb_ifmap_read_sched;
    localparam int W = 8;
    localparam logic [9*W-1:0] NOM  = {8'd3, 8'd3, 8'd3, 8'd3, 8'd1, 8'd5, 8'd5, 8'd2, 8'd1};
    localparam logic [9*W-1:0] ZERO = {8'd3, 8'd3, 8'd0, 8'd3, 8'd1, 8'd5, 8'd5, 8'd2, 8'd1};

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [9*W-1:0] cfg_data;
    logic [7:0]     cfg_tiles;
    logic           bank_ready;
    logic           stall;
    logic           gen_config_en;
    logic [9*W-1:0] gen_config_data;
    logic           gen_adr_en;
    logic           read_valid;
    logic           last_read;
    logic           bank_release;
    logic           busy;
    logic           done;
    logic           cfg_err;

    ifmap_read_sched #(.BANK_ADDR_WIDTH(W), .TILE_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_data       (cfg_data),
        .cfg_tiles      (cfg_tiles),
        .bank_ready     (bank_ready),
        .stall          (stall),
        .gen_config_en  (gen_config_en),
        .gen_config_data(gen_config_data),
        .gen_adr_en     (gen_adr_en),
        .read_valid     (read_valid),
        .last_read      (last_read),
        .bank_release   (bank_release),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    // Clock and cycle index (cyc changes at each rising edge).
    always #5 clk = ~clk;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    longint n_checks = 0;
    longint n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor statistics, cleared while clr is high.
    logic           clr = 1'b0;
    longint         cfg_en_cnt, cfg_en_cyc, first_adr, adr_cnt, adr_bad, adr_in_stall;
    longint         rv_cnt, rv_bad, lr_cnt, lr_at, rel_cnt, rel_cyc;
    longint         done_cnt, done_cyc, err_cnt, done_err;
    logic [9*W-1:0] cfg_seen;
    logic           prev_adr = 1'b0;
    logic           prev_rst = 1'b1;

    always @(negedge clk) begin
        if (clr) begin
            cfg_en_cnt = 0; cfg_en_cyc = -1; first_adr = -1; adr_cnt = 0; adr_bad = 0;
            adr_in_stall = 0; rv_cnt = 0; rv_bad = 0; lr_cnt = 0; lr_at = -1;
            rel_cnt = 0; rel_cyc = -1; done_cnt = 0; done_cyc = -1; err_cnt = 0;
            done_err = 0; cfg_seen = '0;
        end else begin
            if (gen_config_en) begin
                cfg_en_cnt++;
                cfg_en_cyc = cyc;
                cfg_seen   = gen_config_data;
            end
            if (gen_adr_en) begin
                if (adr_cnt == 0) first_adr = cyc;
                adr_cnt++;
                if (!busy) adr_bad++;
                if (stall) adr_in_stall++;
            end
            if (read_valid) rv_cnt++;
            if (read_valid !== (prev_adr && !prev_rst)) rv_bad++;
            if (last_read) begin
                lr_cnt++;
                lr_at = rv_cnt;
            end
            if (bank_release) begin
                rel_cnt++;
                rel_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = longint'(cfg_err);
            end
            if (cfg_err) err_cnt++;
        end
        prev_adr = gen_adr_en;
        prev_rst = rst;
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9*W-1:0] cfg, input logic [7:0] tiles,
                            output longint t);
        clr = 1'b1;
        step();
        clr       = 1'b0;
        cfg_data  = cfg;
        cfg_tiles = tiles;
        start     = 1'b1;
        t         = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input longint need, input int budget);
        int k = 0;
        while (done_cnt < need && k < budget) begin
            step();
            k++;
        end
        check_eq("done_seen", done_cnt, need);
    endtask

    task automatic check_run(input string p, input longint t, input longint reads,
                             input longint rel_at, input longint rels);
        check_eq({p, "_cfg_en_cyc"}, cfg_en_cyc, t + 1);
        check_eq({p, "_cfg_en_cnt"}, cfg_en_cnt, 1);
        check_eq({p, "_cfg_data_lo"}, longint'(cfg_seen[63:0]), longint'(NOM[63:0]));
        check_eq({p, "_cfg_data_hi"}, longint'(cfg_seen[71:64]), longint'(NOM[71:64]));
        check_eq({p, "_first_adr"}, first_adr, t + 3);
        check_eq({p, "_adr_cnt"}, adr_cnt, reads);
        check_eq({p, "_adr_idle"}, adr_bad, 0);
        check_eq({p, "_adr_in_stall"}, adr_in_stall, 0);
        check_eq({p, "_rv_cnt"}, rv_cnt, reads);
        check_eq({p, "_rv_align"}, rv_bad, 0);
        check_eq({p, "_last_cnt"}, lr_cnt, rels);
        check_eq({p, "_last_pos"}, lr_at, reads);
        check_eq({p, "_rel_cnt"}, rel_cnt, rels);
        check_eq({p, "_rel_cyc"}, rel_cyc, rel_at);
        check_eq({p, "_done_cnt"}, done_cnt, 1);
        check_eq({p, "_done_cyc"}, done_cyc, rel_at);
        check_eq({p, "_err_cnt"}, err_cnt, 0);
        step();
        check_eq({p, "_busy_after"}, longint'(busy), 0);
    endtask

    longint t;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_data = '0; cfg_tiles = '0;
        bank_ready = 1'b0; stall = 1'b0;
        clr = 1'b1;
        repeat (3) step();
        clr = 1'b0;
        check_eq("reset_outputs", longint'({gen_config_en, gen_adr_en, read_valid, last_read,
                 bank_release, busy, done, cfg_err}), 0);
        check_eq("reset_cfg_data", longint'(gen_config_data[63:0]), 0);
        rst = 1'b0;
        step();

        // Nominal single tile.
        bank_ready = 1'b1;
        do_start(NOM, 8'd1, t);
        wait_done(1, 400);
        check_run("nom", t, 162, t + 165, 1);

        // Five stall cycles after read 40 (read 40 lands in cycle t+42).
        do_start(NOM, 8'd1, t);
        while (cyc < t + 43) step();
        stall = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        wait_done(1, 400);
        check_run("stall", t, 162, t + 170, 1);

        // Two tiles, bank not ready for 10 cycles after the first release.
        do_start(NOM, 8'd2, t);
        while (cyc < t + 165) step();
        bank_ready = 1'b0;
        repeat (10) step();
        bank_ready = 1'b1;
        wait_done(1, 400);
        check_run("multi", t, 324, t + 338, 2);

        // Zero-sized configuration.
        do_start(ZERO, 8'd1, t);
        wait_done(1, 20);
        check_eq("zero_done_cyc", done_cyc, t + 2);
        check_eq("zero_err_with_done", done_err, 1);
        check_eq("zero_err_cnt", err_cnt, 1);
        check_eq("zero_cfg_en_cyc", cfg_en_cyc, t + 1);
        check_eq("zero_busy", longint'(busy), 0);
        repeat (5) step();
        check_eq("zero_adr_cnt", adr_cnt, 0);
        check_eq("zero_busy_later", longint'(busy), 0);

        // Zero tile count.
        do_start(NOM, 8'd0, t);
        wait_done(1, 20);
        check_eq("zero_tiles_done_cyc", done_cyc, t + 2);
        check_eq("zero_tiles_err", err_cnt, 1);
        check_eq("zero_tiles_adr", adr_cnt, 0);

        // Reset in the middle of a run, with start asserted alongside reset.
        do_start(NOM, 8'd1, t);
        while (cyc < t + 53) step();
        check_eq("rst_reads_before", adr_cnt, 50);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_outputs", longint'({gen_config_en, gen_adr_en, read_valid, last_read,
                 bank_release, busy, done, cfg_err}), 0);
        check_eq("rst_cfg_data", longint'(gen_config_data[63:0]), 0);
        repeat (5) step();
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_no_release", rel_cnt, 0);
        check_eq("rst_no_done", done_cnt, 0);
        check_eq("rst_no_trailing_rv", rv_bad, 0);
        check_eq("rst_start_ignored", cfg_en_cnt, 1);
        do_start(NOM, 8'd1, t);
        wait_done(1, 400);
        check_run("after_rst", t, 162, t + 165, 1);

        // Start pulse during RUN has no effect.
        do_start(NOM, 8'd1, t);
        while (cyc < t + 80) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1, 400);
        check_run("start_in_run", t, 162, t + 165, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifmap_read_sched.md
IFMAP_READ_SCHED -- requirements
Module: ifmap_read_sched

Interface
REQ-001 Parameter BANK_ADDR_WIDTH, default 8: width of each configuration field and of the address generator's address.
REQ-002 Parameter TILE_WIDTH, default 8: width of the tile-count field.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a layer.
REQ-006 cfg_data  input  9*BANK_ADDR_WIDTH  packed {OX0, OY0, FX, FY, STRIDE, IX0, IY0, IC1, OC1}, MSB first.
REQ-007 cfg_tiles  input  TILE_WIDTH  number of ifmap tiles (bank fills) to process in the layer.
REQ-008 bank_ready  input  1  write side reports the read bank is filled.
REQ-009 stall  input  1  downstream cannot accept a read this cycle.
REQ-010 gen_config_en  output  1  config strobe to the ifmap read-address generator.
REQ-011 gen_config_data  output  9*BANK_ADDR_WIDTH  latched cfg_data, forwarded to the generator.
REQ-012 gen_adr_en  output  1  advance/issue-read enable to the generator and the SRAM.
REQ-013 read_valid  output  1  SRAM read data valid; gen_adr_en delayed 1 cycle.
REQ-014 last_read  output  1  qualifies read_valid for the final read of a tile.
REQ-015 bank_release  output  1  one-cycle pulse: read bank consumed, swap allowed.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse at layer end.
REQ-018 cfg_err  output  1  one-cycle pulse: zero-sized configuration rejected.

Function
REQ-019 The FSM SHALL have exactly five states: IDLE, CONFIG, WAIT_BANK, RUN, RELEASE.
REQ-020 In IDLE, start=1 SHALL latch cfg_data and cfg_tiles and move to CONFIG; start in any other state SHALL be ignored.
REQ-021 CONFIG SHALL last 1 cycle, with gen_config_en=1 and gen_config_data=latched fields; read_cnt and tile_cnt clear to 0.
REQ-022 CONFIG SHALL compute total = OX0*OY0*FX*FY*IC1*OC1, full 6*BANK_ADDR_WIDTH-bit width, unsigned, with no truncation; RUN SHALL NOT be entered before total is valid.
REQ-023 If any of OX0, OY0, FX, FY, IC1, OC1 or cfg_tiles is 0, CONFIG SHALL go to IDLE and pulse done and cfg_err together; no gen_adr_en is issued.
REQ-024 Otherwise CONFIG SHALL go to WAIT_BANK.
REQ-025 WAIT_BANK SHALL go to RUN on the cycle after bank_ready=1 is sampled; it waits indefinitely otherwise.
REQ-026 In RUN, gen_adr_en SHALL equal !stall; read_cnt SHALL increment on every cycle with gen_adr_en=1.
REQ-027 When gen_adr_en=1 and read_cnt==total-1, RUN SHALL go to RELEASE; stall on that cycle SHALL hold RUN with no increment.
REQ-028 RELEASE SHALL last 1 cycle, with bank_release=1 and tile_cnt incremented; read_cnt clears.
REQ-029 From RELEASE: if tile_cnt==cfg_tiles-1 before the increment, go to IDLE with done=1 that same cycle; else go to WAIT_BANK. The generator is not reconfigured, because it wraps to address 0 by itself.
REQ-030 read_valid SHALL be gen_adr_en registered once; last_read SHALL be (gen_adr_en && read_cnt==total-1) registered once.
REQ-031 gen_adr_en SHALL be 0 in every state except RUN; bank_release, done, cfg_err and gen_config_en SHALL each be single-cycle pulses.
REQ-032 Timing from start at cycle t: gen_config_en at t+1, WAIT_BANK at t+2, first gen_adr_en at t+3 if bank_ready=1 at t+2.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, clear all counters and latched config, and drive every output to 0 from the next cycle.
REQ-034 Reset mid-RUN SHALL NOT emit bank_release, done or a trailing read_valid.
REQ-035 A start asserted together with rst SHALL be ignored.

Verification
REQ-036 Nominal: cfg {3,3,3,3,1,5,5,2,1}, tiles=1, bank_ready=1 held, stall=0 -> gen_config_en at t+1; gen_adr_en high for 162 consecutive cycles from t+3; bank_release and done at t+165; read_valid 1 cycle behind gen_adr_en; last_read on the 162nd read_valid.
REQ-037 Stall: same config, stall=1 for 5 cycles after read 40 -> gen_adr_en low for those 5 cycles; still exactly 162 reads; done at t+170.
REQ-038 Multi-tile: tiles=2, bank_ready drops for 10 cycles after the first release -> 324 reads, two bank_release pulses, one done, on the second release only.
REQ-039 Zero config: FX=0 -> done and cfg_err together at t+2; busy low afterwards; gen_adr_en never asserted.
REQ-040 Reset mid-run: rst after read 50 -> all outputs 0 next cycle, no release; a fresh start yields the full 162 reads.
REQ-041 start pulsed during RUN -> ignored; read count and done timing identical to REQ-036.
